// File: rtl/multi_port_ram_sync.sv
// Shared 1-write / NUM_PORTS-read table with byte-masked writes and a zeroing sweep.
// Latency: 1 cycle from read_en_i to data_o/valid_o; writes land on the same edge.
// Backpressure: none; while busy_o is high all reads and writes are dropped.
module multi_port_ram_sync #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int NUM_PORTS      = 8,
    parameter bit BYPASS         = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear_i,
    output logic                            busy_o,
    input  logic                            write_en_i,
    input  logic [ADDR_WIDTH-1:0]           write_addr_i,
    input  logic [DATA_WIDTH/8-1:0]         write_be_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    input  logic [NUM_PORTS-1:0]            read_en_i,
    input  logic [ADDR_WIDTH*NUM_PORTS-1:0] read_addr_i,
    output logic [DATA_WIDTH*NUM_PORTS-1:0] data_o,
    output logic [NUM_PORTS-1:0]            valid_o
);
    localparam int MEM_SIZE  = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem [MEM_SIZE];
    logic [DATA_WIDTH-1:0]   wr_merged;
    logic [DATA_WIDTH-1:0]   rd_word [NUM_PORTS];

    assign busy_o = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET) state_q <= CLEAR;
            else                state_q <= IDLE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Merged word is both what gets stored and what a bypassed read sees.
    always_comb begin
        wr_merged = mem[write_addr_i];
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (write_be_i[b]) wr_merged[8*b +: 8] = data_i[8*b +: 8];
        end
    end

    // Array has no reset: rst_n only restarts the sweep.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR)  mem[cnt_q]        <= '0;
        else if (write_en_i)   mem[write_addr_i] <= wr_merged;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ADDR_WIDTH-1:0] raddr;
        assign raddr      = read_addr_i[ADDR_WIDTH*p +: ADDR_WIDTH];
        assign rd_word[p] = (BYPASS && write_en_i && (raddr == write_addr_i)) ? wr_merged
                                                                               : mem[raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o  <= '0;
            valid_o <= '0;
        end else if (state_q == CLEAR) begin
            valid_o <= '0;
        end else begin
            valid_o <= read_en_i;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (read_en_i[p]) data_o[DATA_WIDTH*p +: DATA_WIDTH] <= rd_word[p];
            end
        end
    end
endmodule
